// File: rtl/hamming_pkg.sv
// Shared types and constants for the nibble-granular Hamming(7,4) scrubber.
package hamming_pkg;

  localparam int DEFAULT_WIDTH = 128;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Syndrome bits ordered {s2,s1,s0} to line up with {p2,p1,p0}
  localparam logic [2:0] SYN_NONE = 3'b000;
  localparam logic [2:0] SYN_D0   = 3'b111;
  localparam logic [2:0] SYN_D1   = 3'b011;
  localparam logic [2:0] SYN_D2   = 3'b101;
  localparam logic [2:0] SYN_D3   = 3'b110;
  localparam logic [2:0] SYN_P0   = 3'b001;
  localparam logic [2:0] SYN_P1   = 3'b010;
  localparam logic [2:0] SYN_P2   = 3'b100;

  function automatic logic [2:0] encode_nibble(input logic [3:0] d);
    return {d[0] ^ d[2] ^ d[3], d[0] ^ d[1] ^ d[3], d[0] ^ d[1] ^ d[2]};
  endfunction

endpackage

// File: rtl/hamming_block_fix.sv
// Combinational single-error corrector for one 4-bit data block and its 3 parity bits.
module hamming_block_fix
  import hamming_pkg::*;
(
  input  logic [3:0] i_d,
  input  logic [2:0] i_p,
  output logic [3:0] o_d,
  output logic [2:0] o_p,
  output logic       o_data_err,
  output logic       o_par_err
);

  logic [2:0] w_syn;

  assign w_syn = i_p ^ encode_nibble(i_d);

  // Flip the single bit the syndrome points at and flag which half it was in
  always_comb begin
    o_d        = i_d;
    o_p        = i_p;
    o_data_err = 1'b0;
    o_par_err  = 1'b0;
    case (w_syn)
      SYN_NONE: begin
        o_d = i_d;
      end
      SYN_D0: begin o_d = i_d ^ 4'b0001; o_data_err = 1'b1; end
      SYN_D1: begin o_d = i_d ^ 4'b0010; o_data_err = 1'b1; end
      SYN_D2: begin o_d = i_d ^ 4'b0100; o_data_err = 1'b1; end
      SYN_D3: begin o_d = i_d ^ 4'b1000; o_data_err = 1'b1; end
      SYN_P0: begin o_p = i_p ^ 3'b001; o_par_err = 1'b1; end
      SYN_P1: begin o_p = i_p ^ 3'b010; o_par_err = 1'b1; end
      SYN_P2: begin o_p = i_p ^ 3'b100; o_par_err = 1'b1; end
      default: begin
        o_d = i_d;
        o_p = i_p;
      end
    endcase
  end

endmodule

// File: rtl/hamming_block_scrubber.sv
// Scrubs a captured word one nibble per cycle through a shared corrector, then publishes it.
module hamming_block_scrubber
  import hamming_pkg::*;
#(
  parameter int width       = DEFAULT_WIDTH,
  parameter int blocks      = width / 4,
  parameter int parity_bits = blocks * 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [width-1:0]       data_in,
  input  logic [parity_bits-1:0] parity_in,
  input  logic                   clr_cnt,
  output logic                   busy,
  output logic                   done,
  output logic [width-1:0]       data_out,
  output logic [parity_bits-1:0] parity_out,
  output logic [7:0]             data_err_cnt,
  output logic [7:0]             par_err_cnt
);

  localparam int IDX_W = (blocks > 1) ? $clog2(blocks) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(blocks - 1);

  state_t                 r_state;
  logic [IDX_W-1:0]       r_idx;
  logic [width-1:0]       r_work_data;
  logic [parity_bits-1:0] r_work_par;
  logic                   r_busy;
  logic                   r_done;
  logic [width-1:0]       r_data_out;
  logic [parity_bits-1:0] r_par_out;
  logic [7:0]             r_data_cnt;
  logic [7:0]             r_par_cnt;

  logic [3:0] w_d;
  logic [2:0] w_p;
  logic [3:0] w_d_fix;
  logic [2:0] w_p_fix;
  logic       w_data_err;
  logic       w_par_err;

  assign w_d = r_work_data[r_idx*4 +: 4];
  assign w_p = r_work_par[r_idx*3 +: 3];

  hamming_block_fix u_fix (
    .i_d        (w_d),
    .i_p        (w_p),
    .o_d        (w_d_fix),
    .o_p        (w_p_fix),
    .o_data_err (w_data_err),
    .o_par_err  (w_par_err)
  );

  // Scrub sequencer: capture, walk the blocks, publish
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_idx       <= '0;
      r_work_data <= '0;
      r_work_par  <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_data_out  <= '0;
      r_par_out   <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_work_data <= data_in;
            r_work_par  <= parity_in;
            r_idx       <= '0;
            r_busy      <= 1'b1;
            r_state     <= ST_SCAN;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_SCAN: begin
          r_work_data[r_idx*4 +: 4] <= w_d_fix;
          r_work_par[r_idx*3 +: 3]  <= w_p_fix;
          if (r_idx == LAST_IDX) begin
            r_state <= ST_DONE;
          end else begin
            r_idx <= r_idx + IDX_W'(1);
          end
        end
        ST_DONE: begin
          r_done     <= 1'b1;
          r_data_out <= r_work_data;
          r_par_out  <= r_work_par;
          r_busy     <= 1'b0;
          r_state    <= ST_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Cumulative saturating error counters; a clear beats a same-cycle increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data_cnt <= 8'd0;
      r_par_cnt  <= 8'd0;
    end else if (clr_cnt) begin
      r_data_cnt <= 8'd0;
      r_par_cnt  <= 8'd0;
    end else if (r_state == ST_SCAN) begin
      if (w_data_err && (r_data_cnt != 8'hFF)) begin
        r_data_cnt <= r_data_cnt + 8'd1;
      end
      if (w_par_err && (r_par_cnt != 8'hFF)) begin
        r_par_cnt <= r_par_cnt + 8'd1;
      end
    end
  end

  assign busy         = r_busy;
  assign done         = r_done;
  assign data_out     = r_data_out;
  assign parity_out   = r_par_out;
  assign data_err_cnt = r_data_cnt;
  assign par_err_cnt  = r_par_cnt;

endmodule

// File: tb/tb_hamming_block_scrubber.sv
// Directed bench for hamming_block_scrubber at width=128 (32 blocks, 96 parity bits).
module tb_hamming_block_scrubber;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [127:0] data_in;
  logic [95:0]  parity_in;
  logic         clr_cnt;
  logic         busy;
  logic         done;
  logic [127:0] data_out;
  logic [95:0]  parity_out;
  logic [7:0]   data_err_cnt;
  logic [7:0]   par_err_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  hamming_block_scrubber #(.width(128)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .data_in      (data_in),
    .parity_in    (parity_in),
    .clr_cnt      (clr_cnt),
    .busy         (busy),
    .done         (done),
    .data_out     (data_out),
    .parity_out   (parity_out),
    .data_err_cnt (data_err_cnt),
    .par_err_cnt  (par_err_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Pulse start at a negedge; cycle 1 is the negedge just after the accepting edge.
  // window=0 returns at the first done; window>0 watches that many cycles.
  task automatic scrub(input logic [127:0] d, input logic [95:0] p, input int second_at,
                       input int window, output int lat, output int n_done, output logic busy1);
    int cyc = 0;
    lat    = -1;
    n_done = 0;
    busy1  = 1'b0;
    @(negedge clk);
    data_in   = d;
    parity_in = p;
    start     = 1'b1;
    while (cyc < 100) begin
      @(negedge clk);
      cyc++;
      start = (cyc == second_at);
      if (cyc == 1) busy1 = busy;
      if (done === 1'b1) begin
        n_done++;
        if (lat < 0) lat = cyc;
      end
      if (window == 0 && lat >= 0) break;
      if (window > 0 && cyc >= window) break;
    end
    start = 1'b0;
  endtask

  initial begin
    int   lat;
    int   nd;
    int   bad_lat;
    int   seen;
    logic b1;

    rst_n     = 1'b0;
    start     = 1'b0;
    clr_cnt   = 1'b0;
    data_in   = '0;
    parity_in = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", 128'(busy), 128'd0);
    check("rst_done", 128'(done), 128'd0);
    check("rst_data_out", data_out, 128'd0);
    check("rst_parity_out", 128'(parity_out), 128'd0);
    check("rst_dcnt", 128'(data_err_cnt), 128'd0);
    check("rst_pcnt", 128'(par_err_cnt), 128'd0);
    rst_n = 1'b1;

    // Clean word 0x5: block0 parity {p2,p1,p0} = 010
    scrub(128'h5, 96'h2, 0, 0, lat, nd, b1);
    check("clean_latency", 128'(lat), 128'd34);
    check("clean_busy_next", 128'(b1), 128'd1);
    check("clean_data", data_out, 128'h5);
    check("clean_parity", 128'(parity_out), 128'h2);
    check("clean_dcnt", 128'(data_err_cnt), 128'd0);
    check("clean_pcnt", 128'(par_err_cnt), 128'd0);
    @(negedge clk);
    check("done_one_cycle", 128'(done), 128'd0);
    check("busy_after_done", 128'(busy), 128'd0);

    // Bit 6 (block1 d2) flipped: syndrome 101
    scrub(128'h45, 96'h2, 0, 0, lat, nd, b1);
    check("d2_fix_data", data_out, 128'h5);
    check("d2_fix_parity", 128'(parity_out), 128'h2);
    check("d2_fix_dcnt", 128'(data_err_cnt), 128'd1);
    check("d2_fix_pcnt", 128'(par_err_cnt), 128'd0);

    // Parity bit 4 (block1 p1) flipped: syndrome 010
    scrub(128'h5, 96'h12, 0, 0, lat, nd, b1);
    check("p1_fix_parity", 128'(parity_out), 128'h2);
    check("p1_fix_data", data_out, 128'h5);
    check("p1_fix_pcnt", 128'(par_err_cnt), 128'd1);
    check("p1_fix_dcnt", 128'(data_err_cnt), 128'd1);

    @(negedge clk); clr_cnt = 1'b1;
    @(negedge clk); clr_cnt = 1'b0;
    check("clr_dcnt", 128'(data_err_cnt), 128'd0);
    check("clr_pcnt", 128'(par_err_cnt), 128'd0);

    // Errors in block0 d1 (bit1), block15 d3 (bit63), block31 d2 (bit126); restart while busy
    scrub((128'd1 << 1) | (128'd1 << 63) | (128'd1 << 126), 96'h0, 5, 70, lat, nd, b1);
    check("multi_done_count", 128'(nd), 128'd1);
    check("multi_latency", 128'(lat), 128'd34);
    check("multi_data", data_out, 128'd0);
    check("multi_parity", 128'(parity_out), 128'd0);
    check("multi_dcnt", 128'(data_err_cnt), 128'd3);

    // Saturation: 260 scrubs, each with block0 d0 flipped
    @(negedge clk); clr_cnt = 1'b1;
    @(negedge clk); clr_cnt = 1'b0;
    bad_lat = 0;
    for (int i = 0; i < 260; i++) begin
      scrub(128'h1, 96'h0, 0, 0, lat, nd, b1);
      if (lat != 34) bad_lat++;
    end
    check("sat_latencies", 128'(bad_lat), 128'd0);
    check("sat_dcnt", 128'(data_err_cnt), 128'd255);
    check("sat_pcnt", 128'(par_err_cnt), 128'd0);

    // clr_cnt sampled on the same edge that processes the erroneous block0
    @(negedge clk);
    data_in   = 128'h1;
    parity_in = 96'h0;
    start     = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    clr_cnt = 1'b1;
    @(negedge clk);
    clr_cnt = 1'b0;
    check("clr_priority", 128'(data_err_cnt), 128'd0);
    seen = 0;
    for (int i = 0; i < 60 && seen == 0; i++) begin
      @(negedge clk);
      if (done === 1'b1) seen = 1;
    end
    check("clr_prio_done", 128'(seen), 128'd1);
    check("clr_prio_dcnt_end", 128'(data_err_cnt), 128'd0);

    // Leave non-zero outputs, then abort a scrub at block index 10
    scrub(128'h45, 96'h2, 0, 0, lat, nd, b1);
    check("pre_abort_data", data_out, 128'h5);
    @(negedge clk);
    data_in   = 128'h45;
    parity_in = 96'h2;
    start     = 1'b1;
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    check("abort_busy", 128'(busy), 128'd0);
    check("abort_done", 128'(done), 128'd0);
    check("abort_data", data_out, 128'd0);
    check("abort_parity", 128'(parity_out), 128'd0);
    check("abort_dcnt", 128'(data_err_cnt), 128'd0);
    check("abort_pcnt", 128'(par_err_cnt), 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (done === 1'b1) seen++;
    end
    check("abort_no_done", 128'(seen), 128'd0);
    check("abort_data_hold", data_out, 128'd0);

    scrub(128'h45, 96'h2, 0, 0, lat, nd, b1);
    check("fresh_latency", 128'(lat), 128'd34);
    check("fresh_data", data_out, 128'h5);
    check("fresh_parity", 128'(parity_out), 128'h2);
    check("fresh_dcnt", 128'(data_err_cnt), 128'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
